// File: rtl/ads868x_pkg.sv
// Shared encodings for the ADS868x scan sequencer: FSM states, result-word layout, channel index fields.
package ads868x_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd1;
  localparam logic [2:0] ST_BREAK     = 3'd2;
  localparam logic [2:0] ST_SELECT    = 3'd3;
  localparam logic [2:0] ST_SETTLE    = 3'd4;
  localparam logic [2:0] ST_CONVERT   = 3'd5;
  localparam logic [2:0] ST_EMIT      = 3'd6;

  // Logical channel index: [2:0] mux address, [3] TCH/PCH path, [4] A/B side.
  localparam int IDX_SEL_MSB = 2;
  localparam int IDX_PCH_BIT = 3;
  localparam int IDX_B_BIT   = 4;

  // Stream word layout, MSB first: ch[31:27], first[26], scan_cnt[25:16], data[15:0].
  typedef struct packed {
    logic [4:0]  ch;
    logic        first;
    logic [9:0]  scan_cnt;
    logic [15:0] data;
  } word_t;

  typedef struct packed {
    logic pch_b;
    logic tch_b;
    logic pch_a;
    logic tch_a;
  } en_t;

  function automatic logic [4:0] lowest_set(input logic [31:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) r = 5'(i);
    end
    return r;
  endfunction

  function automatic en_t path_en(input logic [4:0] idx, input logic on);
    en_t e;
    e.tch_a = on && !idx[IDX_B_BIT] && !idx[IDX_PCH_BIT];
    e.pch_a = on && !idx[IDX_B_BIT] &&  idx[IDX_PCH_BIT];
    e.tch_b = on &&  idx[IDX_B_BIT] && !idx[IDX_PCH_BIT];
    e.pch_b = on &&  idx[IDX_B_BIT] &&  idx[IDX_PCH_BIT];
    return e;
  endfunction

endpackage

// File: rtl/ads868x_scan_ctrl_if.sv
// Conversion-engine handshake plus result AXI-Stream between the scan sequencer and its neighbours.
interface ads868x_scan_ctrl_if;

  logic        conv_req;
  logic        conv_ack;
  logic [15:0] conv_data;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (
    output conv_req,
    input  conv_ack,
    input  conv_data,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  conv_req,
    output conv_ack,
    output conv_data,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );

endinterface

// File: rtl/ads868x_next_ch.sv
// Combinational priority finder: lowest set mask bit strictly above cur; last=1 when none remains.
module ads868x_next_ch (
  input  logic [31:0] mask,
  input  logic [4:0]  cur,
  output logic [4:0]  nxt,
  output logic        last
);

  always_comb begin
    nxt  = cur;
    last = 1'b1;
    // Descending scan so the final hit is the lowest qualifying index.
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        nxt  = 5'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ads868x_scan_ctrl.sv
// Scan sequencer: per trigger, walks the latched channel mask through break/select/settle/convert/emit.
// PPS trigger reaches the FSM 3 cycles after the pin; EMIT holds the word until tready, no conversion meanwhile.
import ads868x_pkg::*;

module ads868x_scan_ctrl #(
  parameter int C_SETTLE_W = 16,
  parameter int C_PERIOD_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_enable,
  input  logic [31:0]           cfg_ch_mask,
  input  logic [C_SETTLE_W-1:0] cfg_settle,
  input  logic [C_PERIOD_W-1:0] cfg_period,
  input  logic                  pps,
  ads868x_scan_ctrl_if.master   bus,
  output logic                  CH_SEL_A0,
  output logic                  CH_SEL_A1,
  output logic                  CH_SEL_A2,
  output logic                  EN_TCH_A,
  output logic                  EN_PCH_A,
  output logic                  EN_TCH_B,
  output logic                  EN_PCH_B,
  output logic                  busy,
  output logic [15:0]           overrun_cnt
);

  localparam logic [C_SETTLE_W-1:0] SETTLE_ONE = C_SETTLE_W'(1);
  localparam logic [C_PERIOD_W-1:0] PERIOD_ONE = C_PERIOD_W'(1);

  logic [2:0]            state, state_nxt;
  logic [31:0]           mask_q, mask_nxt;
  logic [4:0]            ch_q, ch_nxt, ch_next_set;
  logic                  ch_last;
  logic                  first_q, first_nxt;
  logic [C_SETTLE_W-1:0] settle_q, settle_nxt;
  logic [9:0]            scan_q, scan_nxt;

  logic                  pps_s1, pps_s2, pps_s3, pps_rise;
  logic [C_PERIOD_W-1:0] tmr;
  logic                  tmr_run, tmr_hit, trig;

  logic                  conv_req_q, tvalid_q, path_on, handshake, overrun_inc;
  word_t                 word_q;
  logic [2:0]            sel_q;
  en_t                   en_q;

  ads868x_next_ch u_next_ch (
    .mask (mask_q),
    .cur  (ch_q),
    .nxt  (ch_next_set),
    .last (ch_last)
  );

  // PPS is asynchronous: two flops to synchronise, a third for the rising-edge compare.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pps_s1 <= 1'b0;
      pps_s2 <= 1'b0;
      pps_s3 <= 1'b0;
    end else begin
      pps_s1 <= pps;
      pps_s2 <= pps_s1;
      pps_s3 <= pps_s2;
    end
  end

  assign pps_rise = pps_s2 && !pps_s3;

  assign tmr_run = cfg_enable && (cfg_period != '0);
  // >= keeps the timer from running away if the period is shrunk below the current count.
  assign tmr_hit = tmr_run && (tmr >= cfg_period - PERIOD_ONE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tmr <= '0;
    end else if (!tmr_run || tmr_hit) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + PERIOD_ONE;
    end
  end

  assign trig        = pps_rise || tmr_hit;
  assign handshake   = (state == ST_EMIT) && bus.m_axis_tready;
  assign overrun_inc = trig && cfg_enable && (state != ST_WAIT_TRIG) && (overrun_cnt != 16'hFFFF);

  always_comb begin
    state_nxt  = state;
    mask_nxt   = mask_q;
    ch_nxt     = ch_q;
    first_nxt  = first_q;
    settle_nxt = settle_q;
    scan_nxt   = scan_q;
    case (state)
      ST_IDLE: begin
        if (cfg_enable) state_nxt = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        if (!cfg_enable) begin
          state_nxt = ST_IDLE;
        end else if (trig && (cfg_ch_mask != '0)) begin
          mask_nxt  = cfg_ch_mask;
          ch_nxt    = lowest_set(cfg_ch_mask);
          first_nxt = 1'b1;
          state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: begin
        state_nxt = cfg_enable ? ST_SELECT : ST_IDLE;
      end
      ST_SELECT: begin
        if (!cfg_enable) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt  = ST_SETTLE;
          settle_nxt = (cfg_settle == '0) ? SETTLE_ONE : cfg_settle;
        end
      end
      ST_SETTLE: begin
        if (!cfg_enable) begin
          state_nxt = ST_IDLE;
        end else if (settle_q <= SETTLE_ONE) begin
          state_nxt = ST_CONVERT;
        end else begin
          settle_nxt = settle_q - SETTLE_ONE;
        end
      end
      ST_CONVERT: begin
        if (bus.conv_ack) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (handshake) begin
          if (ch_last) scan_nxt = scan_q + 10'd1;
          if (!cfg_enable) begin
            state_nxt = ST_IDLE;
          end else if (ch_last) begin
            state_nxt = ST_WAIT_TRIG;
          end else begin
            ch_nxt    = ch_next_set;
            first_nxt = 1'b0;
            state_nxt = ST_BREAK;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign path_on = (state_nxt == ST_SELECT) || (state_nxt == ST_SETTLE) ||
                   (state_nxt == ST_CONVERT) || (state_nxt == ST_EMIT);

  // Outputs are registered from the next state so they line up exactly with the state they belong to.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      ch_q        <= '0;
      first_q     <= 1'b0;
      settle_q    <= '0;
      scan_q      <= '0;
      conv_req_q  <= 1'b0;
      tvalid_q    <= 1'b0;
      busy        <= 1'b0;
      en_q        <= '0;
      sel_q       <= '0;
      word_q      <= '0;
      overrun_cnt <= '0;
    end else begin
      state      <= state_nxt;
      mask_q     <= mask_nxt;
      ch_q       <= ch_nxt;
      first_q    <= first_nxt;
      settle_q   <= settle_nxt;
      scan_q     <= scan_nxt;
      conv_req_q <= (state_nxt == ST_CONVERT);
      tvalid_q   <= (state_nxt == ST_EMIT);
      busy       <= (state_nxt != ST_IDLE) && (state_nxt != ST_WAIT_TRIG);
      en_q       <= path_en(ch_nxt, path_on);
      if (state_nxt == ST_SELECT) sel_q <= ch_nxt[IDX_SEL_MSB:0];
      if ((state == ST_CONVERT) && bus.conv_ack) begin
        word_q <= '{ch: ch_q, first: first_q, scan_cnt: scan_q, data: bus.conv_data};
      end
      if (overrun_inc) overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

  assign bus.conv_req      = conv_req_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = word_q;

  assign CH_SEL_A0 = sel_q[0];
  assign CH_SEL_A1 = sel_q[1];
  assign CH_SEL_A2 = sel_q[2];
  assign EN_TCH_A  = en_q.tch_a;
  assign EN_PCH_A  = en_q.pch_a;
  assign EN_TCH_B  = en_q.tch_b;
  assign EN_PCH_B  = en_q.pch_b;

endmodule

// File: tb/tb_ads868x_scan_ctrl.sv
// Directed bench for ads868x_scan_ctrl with a small ADC responder that encodes the live mux state into conv_data.
module tb_ads868x_scan_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        cfg_enable;
  logic [31:0] cfg_ch_mask;
  logic [15:0] cfg_settle;
  logic [31:0] cfg_period;
  logic        pps;
  logic        CH_SEL_A0, CH_SEL_A1, CH_SEL_A2;
  logic        EN_TCH_A, EN_PCH_A, EN_TCH_B, EN_PCH_B;
  logic        busy;
  logic [15:0] overrun_cnt;

  ads868x_scan_ctrl_if bus();

  int   total = 0;
  int   bad = 0;
  logic ack_en = 1'b1;
  int   ack_delay = 2;
  int   req_rises = 0;
  int   tv_rises = 0;
  int   settle_seen = 0;
  logic [3:0] w_en;
  logic [2:0] w_sel;

  ads868x_scan_ctrl #(.C_SETTLE_W(16), .C_PERIOD_W(32)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cfg_enable  (cfg_enable),
    .cfg_ch_mask (cfg_ch_mask),
    .cfg_settle  (cfg_settle),
    .cfg_period  (cfg_period),
    .pps         (pps),
    .bus         (bus),
    .CH_SEL_A0   (CH_SEL_A0),
    .CH_SEL_A1   (CH_SEL_A1),
    .CH_SEL_A2   (CH_SEL_A2),
    .EN_TCH_A    (EN_TCH_A),
    .EN_PCH_A    (EN_PCH_A),
    .EN_TCH_B    (EN_TCH_B),
    .EN_PCH_B    (EN_PCH_B),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] en_now();
    return {EN_PCH_B, EN_TCH_B, EN_PCH_A, EN_TCH_A};
  endfunction

  function automatic logic [2:0] sel_now();
    return {CH_SEL_A2, CH_SEL_A1, CH_SEL_A0};
  endfunction

  // ADC result encodes the mux index actually driven at conversion time.
  function automatic logic [15:0] mux_code();
    return {8'hA5, 3'b000, EN_TCH_B | EN_PCH_B, EN_PCH_A | EN_PCH_B, CH_SEL_A2, CH_SEL_A1, CH_SEL_A0};
  endfunction

  function automatic logic [31:0] exp_word(input logic [4:0] ch, input logic first, input logic [9:0] sc);
    return {ch, first, sc, 8'hA5, 3'b000, ch};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic pulse_pps();
    @(negedge aclk);
    pps = 1'b1;
    repeat (2) @(negedge aclk);
    pps = 1'b0;
  endtask

  task automatic get_word(input int budget, output logic [31:0] w, output logic ok);
    ok = 1'b0;
    w  = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (bus.m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      w     = bus.m_axis_tdata;
      w_en  = en_now();
      w_sel = sel_now();
      bus.m_axis_tready = 1'b1;
      @(negedge aclk);
      bus.m_axis_tready = 1'b0;
    end
  endtask

  initial begin : adc
    int req_cyc;
    req_cyc = 0;
    bus.conv_ack  = 1'b0;
    bus.conv_data = '0;
    forever begin
      @(negedge aclk);
      bus.conv_ack = 1'b0;
      if (bus.conv_req && ack_en) begin
        req_cyc++;
        if (req_cyc > ack_delay) begin
          bus.conv_ack  = 1'b1;
          bus.conv_data = mux_code();
          req_cyc = 0;
        end
      end else begin
        req_cyc = 0;
      end
    end
  end

  // Counts conversion requests/words and the mux-stable cycles (SELECT + SETTLE) before each request.
  initial begin : mon
    int   en_run;
    logic req_prev, tv_prev;
    en_run = 0;
    req_prev = 1'b0;
    tv_prev = 1'b0;
    forever begin
      @(negedge aclk);
      if (en_now() == 4'd0) en_run = 0;
      else if (!bus.conv_req && !bus.m_axis_tvalid) en_run++;
      if (bus.conv_req && !req_prev) begin
        req_rises++;
        settle_seen = en_run;
      end
      if (bus.m_axis_tvalid && !tv_prev) tv_rises++;
      req_prev = bus.conv_req;
      tv_prev  = bus.m_axis_tvalid;
    end
  end

  initial begin : main
    logic [31:0] w;
    logic        ok;
    logic        stable;
    int          r0, t0;

    aresetn = 1'b1;
    cfg_enable = 1'b0;
    cfg_ch_mask = '0;
    cfg_settle = '0;
    cfg_period = '0;
    pps = 1'b0;
    bus.m_axis_tready = 1'b0;
    #2 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_conv_req", 32'(bus.conv_req), 32'd0);
    check("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_tdata", bus.m_axis_tdata, 32'd0);
    check("rst_en", 32'(en_now()), 32'd0);
    check("rst_sel", 32'(sel_now()), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    aresetn = 1'b1;

    // 1: two channels, PPS trigger latency, break-before-make, settle length
    cfg_ch_mask = 32'h0000_0005;
    cfg_settle = 16'd4;
    cfg_enable = 1'b1;
    repeat (3) @(negedge aclk);
    check("t1_idle_busy", 32'(busy), 32'd0);
    pps = 1'b1;
    repeat (2) @(negedge aclk);
    check("t1_lat2_busy", 32'(busy), 32'd0);
    @(negedge aclk);
    pps = 1'b0;
    check("t1_lat3_busy", 32'(busy), 32'd1);
    check("t1_break_en", 32'(en_now()), 32'd0);
    get_word(40, w, ok);
    check("t1_w0_ok", 32'(ok), 32'd1);
    check("t1_w0_data", w, exp_word(5'd0, 1'b1, 10'd0));
    check("t1_w0_en", 32'(w_en), 32'h1);
    check("t1_w0_sel", 32'(w_sel), 32'd0);
    check("t1_w0_settle", 32'(settle_seen), 32'd5);
    check("t1_gap_en", 32'(en_now()), 32'd0);
    check("t1_gap_busy", 32'(busy), 32'd1);
    get_word(40, w, ok);
    check("t1_w1_ok", 32'(ok), 32'd1);
    check("t1_w1_data", w, exp_word(5'd2, 1'b0, 10'd0));
    check("t1_w1_en", 32'(w_en), 32'h1);
    check("t1_w1_sel", 32'(w_sel), 32'd2);
    check("t1_w1_settle", 32'(settle_seen), 32'd5);
    repeat (2) @(negedge aclk);
    check("t1_end_busy", 32'(busy), 32'd0);
    check("t1_conv_count", 32'(req_rises), 32'd2);

    // 2: top channel on PCH_B, scan counter walks to 1023 and wraps
    cfg_ch_mask = 32'h8000_0000;
    cfg_settle = 16'd1;
    pulse_pps();
    get_word(40, w, ok);
    check("t2_ok", 32'(ok), 32'd1);
    check("t2_data", w, exp_word(5'd31, 1'b1, 10'd1));
    check("t2_en", 32'(w_en), 32'h8);
    check("t2_sel", 32'(w_sel), 32'd7);
    for (int k = 2; k <= 1024; k++) begin
      pulse_pps();
      get_word(40, w, ok);
      check("t2_scan", ok ? w : 32'hDEAD_BEEF, exp_word(5'd31, 1'b1, 10'(k)));
    end

    // 3: downstream stall holds the word and blocks further conversions
    cfg_ch_mask = 32'h0001_0000;
    cfg_settle = 16'd2;
    pulse_pps();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (bus.m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    check("t3_valid", 32'(ok), 32'd1);
    w = bus.m_axis_tdata;
    r0 = req_rises;
    check("t3_data", w, exp_word(5'd16, 1'b1, 10'd1));
    check("t3_en", 32'(en_now()), 32'h4);
    stable = 1'b1;
    repeat (50) begin
      @(negedge aclk);
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== w || bus.conv_req !== 1'b0) stable = 1'b0;
    end
    check("t3_stable", 32'(stable), 32'd1);
    check("t3_no_req", 32'(req_rises), 32'(r0));
    bus.m_axis_tready = 1'b1;
    @(negedge aclk);
    bus.m_axis_tready = 1'b0;
    check("t3_drop_valid", 32'(bus.m_axis_tvalid), 32'd0);

    // 4: timer triggers land inside a long settle and are counted as overruns
    cfg_ch_mask = 32'h0000_0001;
    cfg_settle = 16'd200;
    @(negedge aclk);
    check("t4_pre_overrun", 32'(overrun_cnt), 32'd0);
    r0 = req_rises;
    cfg_period = 32'd100;
    get_word(450, w, ok);
    cfg_period = 32'd0;
    check("t4_ok", 32'(ok), 32'd1);
    check("t4_data", w, exp_word(5'd0, 1'b1, 10'd2));
    check("t4_settle", 32'(settle_seen), 32'd201);
    check("t4_overrun", 32'(overrun_cnt), 32'd2);
    repeat (150) @(negedge aclk);
    check("t4_one_conv", 32'(req_rises), 32'(r0 + 1));
    check("t4_overrun_hold", 32'(overrun_cnt), 32'd2);

    // 5: enable dropped while a conversion is pending; zero settle runs one cycle
    cfg_ch_mask = 32'h0000_0005;
    cfg_settle = 16'd0;
    ack_en = 1'b0;
    pulse_pps();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (bus.conv_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("t5_req_seen", 32'(ok), 32'd1);
    cfg_enable = 1'b0;
    repeat (5) @(negedge aclk);
    check("t5_req_held", 32'(bus.conv_req), 32'd1);
    check("t5_busy_held", 32'(busy), 32'd1);
    check("t5_settle0", 32'(settle_seen), 32'd2);
    ack_en = 1'b1;
    get_word(20, w, ok);
    check("t5_ok", 32'(ok), 32'd1);
    check("t5_data", w, exp_word(5'd0, 1'b1, 10'd3));
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_en", 32'(en_now()), 32'd0);
    check("t5_idle_req", 32'(bus.conv_req), 32'd0);
    r0 = req_rises;
    repeat (20) @(negedge aclk);
    check("t5_no_more_req", 32'(req_rises), 32'(r0));
    check("t5_no_valid", 32'(bus.m_axis_tvalid), 32'd0);

    // 6: reset mid-settle clears everything at once; empty mask ignores triggers
    cfg_enable = 1'b1;
    cfg_ch_mask = 32'h0000_0020;
    cfg_settle = 16'd200;
    repeat (2) @(negedge aclk);
    pulse_pps();
    repeat (20) @(negedge aclk);
    check("t6_pre_en", 32'(en_now()), 32'h1);
    check("t6_pre_sel", 32'(sel_now()), 32'd5);
    aresetn = 1'b0;
    #1;
    check("t6_rst_en", 32'(en_now()), 32'd0);
    check("t6_rst_sel", 32'(sel_now()), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_tdata", bus.m_axis_tdata, 32'd0);
    check("t6_rst_overrun", 32'(overrun_cnt), 32'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    cfg_ch_mask = 32'h0;
    cfg_settle = 16'd4;
    repeat (3) @(negedge aclk);
    r0 = req_rises;
    t0 = tv_rises;
    pulse_pps();
    repeat (30) @(negedge aclk);
    check("t6_mask0_req", 32'(req_rises), 32'(r0));
    check("t6_mask0_valid", 32'(tv_rises), 32'(t0));
    check("t6_mask0_overrun", 32'(overrun_cnt), 32'd0);
    check("t6_mask0_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
